// File: rtl/memory_stage.sv
// ME stage of the 5-stage RISC-V pipeline: data-memory req/gnt/rvalid handshake, load alignment, ME/WB register.
// Optional: define ME_MISALIGN_CHECK_EN to add misalign_o and suppress misaligned H/W accesses.
module memory_stage #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ex_valid_i,
    input  logic              ex_rf_we_i,
    input  logic [ADDR_W-1:0] ex_rf_waddr_i,
    input  logic              ex_mem2rf_i,
    input  logic              ex_mem_we_i,
    input  logic [2:0]        ex_funct3_i,
    input  logic [DATA_W-1:0] ex_alu_result_i,
    input  logic [DATA_W-1:0] ex_wdata_i,
    output logic              stall_o,
    output logic              dmem_req_o,
    output logic              dmem_we_o,
    output logic [DATA_W-1:0] dmem_addr_o,
    output logic [DATA_W-1:0] dmem_wdata_o,
    output logic [3:0]        dmem_be_o,
    input  logic              dmem_gnt_i,
    input  logic              dmem_rvalid_i,
    input  logic [DATA_W-1:0] dmem_rdata_i,
    output logic              rf_we_o,
    output logic [ADDR_W-1:0] rf_waddr_o,
    output logic              mem2rf_o,
    output logic [DATA_W-1:0] mem_rdata_o,
    output logic [DATA_W-1:0] alu_result_o,
`ifdef ME_MISALIGN_CHECK_EN
    output logic              misalign_o,
`endif
    output logic [DATA_W-1:0] fwd_data_o,
    output logic [ADDR_W-1:0] fwd_dst_o,
    output logic              fwd_we_o
);

    typedef enum logic [1:0] {IDLE, WAIT_GNT, WAIT_RVALID} state_t;

    state_t            state_q, state_d;
    logic              rf_we_q, rf_we_d;
    logic [ADDR_W-1:0] rf_waddr_q, rf_waddr_d;
    logic              mem2rf_q, mem2rf_d;
    logic [DATA_W-1:0] mem_rdata_q, mem_rdata_d;
    logic [DATA_W-1:0] alu_result_q, alu_result_d;
    logic              misalign_q, misalign_d;

    logic              is_mem, misalign, mem_go;
    logic              req, stall, complete;
    logic [1:0]        a_lo;
    logic [7:0]        byte_sel;
    logic [15:0]       half_sel;
    logic [DATA_W-1:0] load_data;

    assign is_mem = ex_mem2rf_i | ex_mem_we_i;
    assign a_lo   = ex_alu_result_i[1:0];

`ifdef ME_MISALIGN_CHECK_EN
    assign misalign = ((ex_funct3_i[1:0] == 2'b01) & a_lo[0]) |
                      ((ex_funct3_i[1:0] == 2'b10) & (a_lo != 2'b00));
`else
    assign misalign = 1'b0;
`endif

    assign mem_go = ex_valid_i & is_mem & ~misalign;

    // Bypass taps: loads are excluded since their data is not known yet.
    assign fwd_data_o = ex_alu_result_i;
    assign fwd_dst_o  = ex_rf_waddr_i;
    assign fwd_we_o   = ex_valid_i & ex_rf_we_i & ~ex_mem2rf_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (mem_go) begin
                    if (!dmem_gnt_i)      state_d = WAIT_GNT;
                    else if (ex_mem2rf_i) state_d = WAIT_RVALID;
                end
            end
            WAIT_GNT: begin
                if (dmem_gnt_i) state_d = ex_mem2rf_i ? WAIT_RVALID : IDLE;
            end
            WAIT_RVALID: begin
                if (dmem_rvalid_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // complete marks the cycle in which the instruction leaves ME and WB regs capture it.
    always_comb begin
        req      = 1'b0;
        stall    = 1'b0;
        complete = 1'b0;
        case (state_q)
            IDLE: begin
                req      = mem_go;
                complete = (ex_valid_i & ~is_mem) | (mem_go & dmem_gnt_i & ~ex_mem2rf_i);
                stall    = mem_go & ~(dmem_gnt_i & ~ex_mem2rf_i);
            end
            WAIT_GNT: begin
                req      = 1'b1;
                complete = dmem_gnt_i & ~ex_mem2rf_i;
                stall    = ~complete;
            end
            WAIT_RVALID: begin
                complete = dmem_rvalid_i;
                stall    = ~dmem_rvalid_i;
            end
            default: ;
        endcase
    end

    assign stall_o    = stall & rst_n;
    assign dmem_req_o = req & rst_n;
    assign dmem_we_o  = ex_mem_we_i & ~ex_mem2rf_i;
    assign dmem_addr_o = {ex_alu_result_i[DATA_W-1:2], 2'b00};

    always_comb begin
        dmem_wdata_o = ex_wdata_i;
        dmem_be_o    = 4'b1111;
        case (ex_funct3_i[1:0])
            2'b00: begin
                dmem_wdata_o = {4{ex_wdata_i[7:0]}};
                dmem_be_o    = 4'b0001 << a_lo;
            end
            2'b01: begin
                dmem_wdata_o = {2{ex_wdata_i[15:0]}};
                dmem_be_o    = 4'b0011 << {a_lo[1], 1'b0};
            end
            default: ;
        endcase
    end

    always_comb begin
        case (a_lo)
            2'b00:   byte_sel = dmem_rdata_i[7:0];
            2'b01:   byte_sel = dmem_rdata_i[15:8];
            2'b10:   byte_sel = dmem_rdata_i[23:16];
            default: byte_sel = dmem_rdata_i[31:24];
        endcase
        half_sel = a_lo[1] ? dmem_rdata_i[31:16] : dmem_rdata_i[15:0];
        case (ex_funct3_i)
            3'b000:  load_data = {{(DATA_W-8){byte_sel[7]}}, byte_sel};
            3'b001:  load_data = {{(DATA_W-16){half_sel[15]}}, half_sel};
            3'b100:  load_data = {{(DATA_W-8){1'b0}}, byte_sel};
            3'b101:  load_data = {{(DATA_W-16){1'b0}}, half_sel};
            default: load_data = dmem_rdata_i;
        endcase
    end

    // Non-completing cycles insert a bubble; data fields hold their last value.
    always_comb begin
        rf_we_d      = complete & ex_rf_we_i;
        mem2rf_d     = complete & ex_mem2rf_i;
        rf_waddr_d   = complete ? ex_rf_waddr_i : rf_waddr_q;
        alu_result_d = complete ? ex_alu_result_i : alu_result_q;
        mem_rdata_d  = (complete & ex_mem2rf_i) ? load_data : mem_rdata_q;
        misalign_d   = (state_q == IDLE) & ex_valid_i & is_mem & misalign;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_we_q      <= 1'b0;
            rf_waddr_q   <= '0;
            mem2rf_q     <= 1'b0;
            mem_rdata_q  <= '0;
            alu_result_q <= '0;
            misalign_q   <= 1'b0;
        end else begin
            rf_we_q      <= rf_we_d;
            rf_waddr_q   <= rf_waddr_d;
            mem2rf_q     <= mem2rf_d;
            mem_rdata_q  <= mem_rdata_d;
            alu_result_q <= alu_result_d;
            misalign_q   <= misalign_d;
        end
    end

    assign rf_we_o      = rf_we_q;
    assign rf_waddr_o   = rf_waddr_q;
    assign mem2rf_o     = mem2rf_q;
    assign mem_rdata_o  = mem_rdata_q;
    assign alu_result_o = alu_result_q;
`ifdef ME_MISALIGN_CHECK_EN
    assign misalign_o   = misalign_q;
`else
    logic unused_misalign;
    assign unused_misalign = misalign_q;
`endif

endmodule

// File: tb/tb_memory_stage.sv
// Scoreboard bench for memory_stage: stimulus pushes expected dmem requests and WB writes, a monitor pops and compares.
module tb_memory_stage;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex_valid, ex_rf_we, ex_mem2rf, ex_mem_we;
    logic [4:0]  ex_rf_waddr;
    logic [2:0]  ex_funct3;
    logic [31:0] ex_alu, ex_wdata;
    logic        stall_o, dmem_req_o, dmem_we_o;
    logic [31:0] dmem_addr_o, dmem_wdata_o;
    logic [3:0]  dmem_be_o;
    logic        dmem_gnt, dmem_rvalid;
    logic [31:0] dmem_rdata;
    logic        rf_we_o, mem2rf_o, fwd_we_o;
    logic [4:0]  rf_waddr_o, fwd_dst_o;
    logic [31:0] mem_rdata_o, alu_result_o, fwd_data_o;
`ifdef ME_MISALIGN_CHECK_EN
    logic        misalign_o;
`endif

    always #5 clk = ~clk;

    memory_stage #(.ADDR_W(5), .DATA_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .ex_valid_i(ex_valid), .ex_rf_we_i(ex_rf_we), .ex_rf_waddr_i(ex_rf_waddr),
        .ex_mem2rf_i(ex_mem2rf), .ex_mem_we_i(ex_mem_we), .ex_funct3_i(ex_funct3),
        .ex_alu_result_i(ex_alu), .ex_wdata_i(ex_wdata),
        .stall_o(stall_o), .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o),
        .dmem_addr_o(dmem_addr_o), .dmem_wdata_o(dmem_wdata_o), .dmem_be_o(dmem_be_o),
        .dmem_gnt_i(dmem_gnt), .dmem_rvalid_i(dmem_rvalid), .dmem_rdata_i(dmem_rdata),
        .rf_we_o(rf_we_o), .rf_waddr_o(rf_waddr_o), .mem2rf_o(mem2rf_o),
        .mem_rdata_o(mem_rdata_o), .alu_result_o(alu_result_o),
`ifdef ME_MISALIGN_CHECK_EN
        .misalign_o(misalign_o),
`endif
        .fwd_data_o(fwd_data_o), .fwd_dst_o(fwd_dst_o), .fwd_we_o(fwd_we_o)
    );

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        logic [3:0]  be;
    } dreq_t;

    typedef struct packed {
        logic [4:0]  waddr;
        logic        mem2rf;
        logic [31:0] rdata;
        logic [31:0] alu;
    } wb_t;

    dreq_t dq[$];
    wb_t   wq[$];
    dreq_t de;
    wb_t   we_exp;
    int    pass_cnt = 0;
    int    total_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Monitor: samples on the falling edge, away from input changes and register updates.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (dmem_req_o && dmem_gnt) begin
                if (dq.size() == 0) begin
                    total_cnt++;
                    $display("FAIL dmem_unexpected_req: got addr %h, expected no request", dmem_addr_o);
                end else begin
                    de = dq.pop_front();
                    chk("dmem_addr", dmem_addr_o, de.addr);
                    chk("dmem_we", {31'd0, dmem_we_o}, {31'd0, de.we});
                    if (de.we) begin
                        chk("dmem_wdata", dmem_wdata_o, de.wdata);
                        chk("dmem_be", {28'd0, dmem_be_o}, {28'd0, de.be});
                    end
                end
            end
            if (rf_we_o || mem2rf_o) begin
                if (wq.size() == 0) begin
                    total_cnt++;
                    $display("FAIL wb_unexpected_write: got waddr %0d, expected bubble", rf_waddr_o);
                end else begin
                    we_exp = wq.pop_front();
                    chk("wb_rf_we", {31'd0, rf_we_o}, 32'd1);
                    chk("wb_waddr", {27'd0, rf_waddr_o}, {27'd0, we_exp.waddr});
                    chk("wb_mem2rf", {31'd0, mem2rf_o}, {31'd0, we_exp.mem2rf});
                    chk("wb_alu", alu_result_o, we_exp.alu);
                    if (we_exp.mem2rf) chk("wb_rdata", mem_rdata_o, we_exp.rdata);
                end
            end
        end
    end

    task automatic idle_inputs();
        ex_valid = 0; ex_rf_we = 0; ex_mem2rf = 0; ex_mem_we = 0;
        ex_rf_waddr = 0; ex_funct3 = 0; ex_alu = 0; ex_wdata = 0;
        dmem_gnt = 0; dmem_rvalid = 0; dmem_rdata = 0;
    endtask

    // One load/store with gnt after gdly extra cycles; loads see rvalid one cycle after gnt.
    task automatic mem_op(input string name, input bit ld, input logic [2:0] f3, input logic [4:0] wa,
                          input logic [31:0] addr, input logic [31:0] wd, input int gdly,
                          input logic [31:0] rd, input logic [31:0] exp_wdata, input logic [3:0] exp_be,
                          input logic [31:0] exp_rdata, input int exp_stalls);
        int stalls;
        stalls = 0;
        dq.push_back('{addr: {addr[31:2], 2'b00}, we: !ld, wdata: exp_wdata, be: exp_be});
        if (ld) wq.push_back('{waddr: wa, mem2rf: 1'b1, rdata: exp_rdata, alu: addr});
        ex_valid = 1; ex_mem2rf = ld; ex_mem_we = !ld; ex_rf_we = ld; ex_rf_waddr = wa;
        ex_funct3 = f3; ex_alu = addr; ex_wdata = wd;
        for (int i = 0; i <= gdly; i++) begin
            dmem_gnt = (i == gdly);
            #1;
            if (stall_o) stalls++;
            @(posedge clk); #1;
        end
        dmem_gnt = 0;
        if (ld) begin
            dmem_rvalid = 1; dmem_rdata = rd;
            #1;
            if (stall_o) stalls++;
            chk({name, "_bubble"}, {31'd0, rf_we_o}, 32'd0);
            @(posedge clk); #1;
            dmem_rvalid = 0;
        end
        ex_valid = 0; ex_mem2rf = 0; ex_mem_we = 0; ex_rf_we = 0;
        chk({name, "_stalls"}, stalls, exp_stalls);
    endtask

    initial begin
        idle_inputs();
        rst_n = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rf_we", {31'd0, rf_we_o}, 32'd0);
        chk("rst_mem2rf", {31'd0, mem2rf_o}, 32'd0);
        chk("rst_alu", alu_result_o, 32'd0);
        chk("rst_rdata", mem_rdata_o, 32'd0);
        chk("rst_stall", {31'd0, stall_o}, 32'd0);
        chk("rst_req", {31'd0, dmem_req_o}, 32'd0);
        rst_n = 1;
        @(posedge clk); #1;

        // ALU op with forwarding taps
        wq.push_back('{waddr: 5'd5, mem2rf: 1'b0, rdata: 32'd0, alu: 32'h1234});
        ex_valid = 1; ex_rf_we = 1; ex_rf_waddr = 5; ex_alu = 32'h1234;
        #1;
        chk("alu_req", {31'd0, dmem_req_o}, 32'd0);
        chk("alu_stall", {31'd0, stall_o}, 32'd0);
        chk("fwd_we", {31'd0, fwd_we_o}, 32'd1);
        chk("fwd_data", fwd_data_o, 32'h1234);
        chk("fwd_dst", {27'd0, fwd_dst_o}, 32'd5);
        @(posedge clk); #1;
        ex_valid = 0; ex_rf_we = 0;
        @(posedge clk); #1;

        mem_op("sb", 0, 3'b000, 5'd0, 32'h103, 32'h000000AB, 0, 32'h0, 32'hABABABAB, 4'b1000, 32'h0, 0);
        mem_op("lb", 1, 3'b000, 5'd7, 32'h101, 32'h0, 2, 32'h11228033, 32'h0, 4'b0010, 32'hFFFFFF80, 3);
        mem_op("lhu", 1, 3'b101, 5'd8, 32'h102, 32'h0, 0, 32'h8001FFFF, 32'h0, 4'b1100, 32'h00008001, 1);
        mem_op("lh", 1, 3'b001, 5'd9, 32'h102, 32'h0, 0, 32'h8001FFFF, 32'h0, 4'b1100, 32'hFFFF8001, 1);
        mem_op("lbu", 1, 3'b100, 5'd10, 32'h103, 32'h0, 1, 32'h9A000000, 32'h0, 4'b1000, 32'h0000009A, 2);
        mem_op("sh", 0, 3'b001, 5'd0, 32'h102, 32'hCAFE1234, 1, 32'h0, 32'h12341234, 4'b1100, 32'h0, 1);
        mem_op("sw", 0, 3'b010, 5'd0, 32'h204, 32'hDEADBEEF, 0, 32'h0, 32'hDEADBEEF, 4'b1111, 32'h0, 0);
        mem_op("lw", 1, 3'b010, 5'd11, 32'h100, 32'h0, 0, 32'h8001FFFF, 32'h0, 4'b1111, 32'h8001FFFF, 1);
        @(posedge clk); #1;

        // Reset while waiting for rvalid
        dq.push_back('{addr: 32'h200, we: 1'b0, wdata: 32'h0, be: 4'b1111});
        ex_valid = 1; ex_mem2rf = 1; ex_rf_we = 1; ex_rf_waddr = 12; ex_funct3 = 3'b010; ex_alu = 32'h200;
        chk("ld_fwd_we", {31'd0, fwd_we_o}, 32'd0);
        dmem_gnt = 1;
        @(posedge clk); #1;
        dmem_gnt = 0;
        chk("pre_rst_stall", {31'd0, stall_o}, 32'd1);
        rst_n = 0;
        #1;
        chk("mid_rst_rf_we", {31'd0, rf_we_o}, 32'd0);
        chk("mid_rst_waddr", {27'd0, rf_waddr_o}, 32'd0);
        chk("mid_rst_alu", alu_result_o, 32'd0);
        chk("mid_rst_rdata", mem_rdata_o, 32'd0);
        chk("mid_rst_stall", {31'd0, stall_o}, 32'd0);
        chk("mid_rst_req", {31'd0, dmem_req_o}, 32'd0);
        idle_inputs();
        @(posedge clk); #1;
        rst_n = 1;
        @(posedge clk); #1;
        dmem_rvalid = 1; dmem_rdata = 32'hDEADBEEF;
        @(posedge clk); #1;
        dmem_rvalid = 0;
        chk("late_rvalid_we", {31'd0, rf_we_o}, 32'd0);
        chk("late_rvalid_rdata", mem_rdata_o, 32'd0);

`ifdef ME_MISALIGN_CHECK_EN
        ex_valid = 1; ex_mem2rf = 1; ex_rf_we = 1; ex_rf_waddr = 13; ex_funct3 = 3'b010; ex_alu = 32'h102;
        #1;
        chk("mis_req", {31'd0, dmem_req_o}, 32'd0);
        chk("mis_stall", {31'd0, stall_o}, 32'd0);
        @(posedge clk); #1;
        idle_inputs();
        chk("mis_flag", {31'd0, misalign_o}, 32'd1);
        chk("mis_rf_we", {31'd0, rf_we_o}, 32'd0);
        @(posedge clk); #1;
        chk("mis_pulse", {31'd0, misalign_o}, 32'd0);
`endif

        repeat (3) @(posedge clk);
        #1;
        chk("dq_drained", dq.size(), 32'd0);
        chk("wq_drained", wq.size(), 32'd0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish, expected finish before 100000");
        $fatal(1);
    end
endmodule
